// File: rtl/uart_cmd_pkg.sv
// Shared state encoding and frame constants for the UART command responder.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_SUM,
    ST_EXEC,
    ST_RD_WAIT,
    ST_RSP_LOAD,
    ST_RSP_BUSY,
    ST_RSP_DONE
  } state_e;

  localparam logic [7:0] CMD_WRITE      = 8'h01;
  localparam logic [7:0] CMD_READ       = 8'h02;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BAD_SUM = 8'hE1;
  localparam logic [7:0] STATUS_BAD_CMD = 8'hE2;

  function automatic logic is_get_state(input state_e s);
    return (s == ST_GET_CMD) || (s == ST_GET_ADDR) ||
           (s == ST_GET_DATA) || (s == ST_GET_SUM);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable saturating up-counter with synchronous clear and a terminal-count flag.
// Used by uart_cmd_responder only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout #(
  parameter int unsigned           WIDTH    = 24,
  parameter logic [WIDTH-1:0]      TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             terminal
);

  logic [WIDTH-1:0] count_d, count_q;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable && (count_q < TERMINAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q >= TERMINAL);

endmodule

// File: rtl/uart_cmd_responder.sv
// Host-facing command responder: 5-byte command frame in, one register access, 4-byte response out.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_RX        = 8'hA5,
  parameter logic [7:0]  SYNC_TX        = 8'h5A,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       received,
  input  logic       recv_error,
  output logic [7:0] tx_byte,
  output logic       transmit,
  input  logic       is_transmitting,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_error
);

  state_e     state_d, state_q;
  logic [7:0] cmd_d, cmd_q;
  logic [7:0] addr_d, addr_q;
  logic [7:0] data_d, data_q;
  logic [7:0] status_d, status_q;
  logic [7:0] rsp_data_d, rsp_data_q;
  logic [1:0] idx_d, idx_q;
  logic [7:0] tx_byte_d, tx_byte_q;
  logic [7:0] reg_addr_d, reg_addr_q;
  logic [7:0] reg_wdata_d, reg_wdata_q;
  logic       reg_we_d, reg_we_q;
  logic       reg_re_d, reg_re_q;
  logic       frame_error_d, frame_error_q;

  logic       in_get;
  logic       timeout_hit;
  logic [1:0] next_idx;
  logic [7:0] next_rsp_byte;

  assign in_get   = is_get_state(state_q);
  assign next_idx = idx_q + 2'd1;

`ifdef UART_CMD_TIMEOUT_EN
  logic timeout_tc;

  uart_cmd_timeout #(
    .WIDTH    (24),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clear      (received || !in_get),
    .enable     (in_get),
    .load       (1'b0),
    .load_value (24'd0),
    .terminal   (timeout_tc)
  );

  assign timeout_hit = timeout_tc && in_get;
`else
  // Without the timeout a partial frame waits until more bytes, recv_error or reset.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 24'd0);
`endif

  always_comb begin
    next_rsp_byte = SYNC_TX;
    case (next_idx)
      2'd1:    next_rsp_byte = status_q;
      2'd2:    next_rsp_byte = rsp_data_q;
      2'd3:    next_rsp_byte = status_q ^ rsp_data_q;
      default: next_rsp_byte = SYNC_TX;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    status_d      = status_q;
    rsp_data_d    = rsp_data_q;
    idx_d         = idx_q;
    tx_byte_d     = tx_byte_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    reg_we_d      = 1'b0;
    reg_re_d      = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (received && (rx_byte == SYNC_RX)) state_d = ST_GET_CMD;
      end
      ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_SUM: begin
        // A received byte in the same cycle as a timeout keeps the frame alive.
        if (recv_error) begin
          state_d       = ST_HUNT;
          frame_error_d = 1'b1;
        end else if (received) begin
          case (state_q)
            ST_GET_CMD:  begin cmd_d  = rx_byte; state_d = ST_GET_ADDR; end
            ST_GET_ADDR: begin addr_d = rx_byte; state_d = ST_GET_DATA; end
            ST_GET_DATA: begin data_d = rx_byte; state_d = ST_GET_SUM;  end
            default: begin
              state_d     = ST_EXEC;
              reg_addr_d  = addr_q;
              reg_wdata_d = data_q;
              if (rx_byte != (cmd_q ^ addr_q ^ data_q)) begin
                status_d      = STATUS_BAD_SUM;
                frame_error_d = 1'b1;
              end else if (cmd_q == CMD_WRITE) begin
                status_d = STATUS_OK;
                reg_we_d = 1'b1;
              end else if (cmd_q == CMD_READ) begin
                status_d = STATUS_OK;
                reg_re_d = 1'b1;
              end else begin
                status_d      = STATUS_BAD_CMD;
                frame_error_d = 1'b1;
              end
            end
          endcase
        end else if (timeout_hit) begin
          state_d       = ST_HUNT;
          frame_error_d = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (status_q != STATUS_OK)  rsp_data_d = 8'h00;
        else if (cmd_q == CMD_READ) rsp_data_d = reg_rdata;
        else                        rsp_data_d = data_q;
        idx_d     = 2'd0;
        tx_byte_d = SYNC_TX;
        state_d   = ST_RSP_LOAD;
      end
      ST_RSP_LOAD: begin
        if (!is_transmitting) state_d = ST_RSP_BUSY;
      end
      ST_RSP_BUSY: begin
        if (is_transmitting) state_d = ST_RSP_DONE;
      end
      ST_RSP_DONE: begin
        if (!is_transmitting) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = ST_HUNT;
          end else begin
            idx_d     = next_idx;
            tx_byte_d = next_rsp_byte;
            state_d   = ST_RSP_LOAD;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_HUNT;
      cmd_q         <= 8'h00;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      status_q      <= 8'h00;
      rsp_data_q    <= 8'h00;
      idx_q         <= 2'd0;
      tx_byte_q     <= 8'h00;
      reg_addr_q    <= 8'h00;
      reg_wdata_q   <= 8'h00;
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      status_q      <= status_d;
      rsp_data_q    <= rsp_data_d;
      idx_q         <= idx_d;
      tx_byte_q     <= tx_byte_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_we_q      <= reg_we_d;
      reg_re_q      <= reg_re_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Decoded from the state flop so an asynchronous reset drops the request at once.
  assign transmit    = (state_q == ST_RSP_LOAD) && !is_transmitting;
  assign busy        = (state_q != ST_HUNT);
  assign tx_byte     = tx_byte_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign frame_error = frame_error_q;

endmodule
